prime_key_enc: RTL and testbench

PRIME_KEY_ENC -- requirements
Module: prime_key_enc

---
 rtl/prime_key_enc_pkg.sv | 8 +
 rtl/prime_key_enc_key_debounce.sv | 39 +++
 rtl/prime_key_enc.sv | 94 +++++++++
 tb/tb_prime_key_enc.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prime_key_enc_pkg.sv
// prime_key_enc_pkg: shared game state encodings, buffer depth and entry FSM states
package prime_key_enc_pkg;
    localparam logic [3:0] ST_READY    = 4'b0010;
    localparam logic [3:0] ST_QUESTION = 4'b0011;
    localparam logic [3:0] ST_INPUT    = 4'b0100;
    localparam int MAX_FACT_DEF = 4;
    typedef enum logic [1:0] {FSM_IDLE, FSM_SELECT, FSM_FINISHED} fsm_e;
endpackage

// File: rtl/prime_key_enc_key_debounce.sv
// key_debounce: 2-flop synchronizer, counter debouncer and press pulse for one active-low key
module key_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic press_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          press_q;
    // Level flips only after DEB_CYCLES consecutive samples that disagree with it
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (sync_q[1] != lvl_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) lvl_d = ~lvl_q;
            else cnt_d = cnt_q + CW'(1);
        end
    end
    // Synchronizer, debounce state and registered falling-edge pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            lvl_q   <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_ni};
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            press_q <= lvl_q & ~lvl_d;
        end
    end
    assign press_o = press_q;
endmodule

// File: rtl/prime_key_enc.sv
// prime_key_enc: key-driven selection and commit of factor indices during the INPUT game state
module prime_key_enc
    import prime_key_enc_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int MAX_FACT   = MAX_FACT_DEF
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [3:0]            STATE,
    input  logic                  nKEY_NEXT,
    input  logic                  nKEY_OK,
    output logic [3:0]            SEG_Q,
    output logic [4*MAX_FACT-1:0] FACTS,
    output logic [2:0]            FCNT,
    output logic                  FULL,
    output logic                  DONE
);
    fsm_e                  fsm_q, fsm_d;
    logic [3:0]            seg_q, seg_d;
    logic [4*MAX_FACT-1:0] facts_q, facts_d;
    logic [2:0]            fcnt_q, fcnt_d;
    logic                  done_q, done_d;
    logic                  next_ev, ok_ev, full;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next (
        .clk_i(CLK), .rst_ni(nRST), .key_ni(nKEY_NEXT), .press_o(next_ev)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ok (
        .clk_i(CLK), .rst_ni(nRST), .key_ni(nKEY_OK), .press_o(ok_ev)
    );

    assign full = fcnt_q == 3'(MAX_FACT);

    // Entry FSM: OK beats NEXT; leaving INPUT drops the selection, READY wipes the buffer
    always_comb begin
        fsm_d   = fsm_q;
        seg_d   = seg_q;
        facts_d = facts_q;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;
        if (STATE != ST_INPUT) begin
            fsm_d = FSM_IDLE;
            seg_d = '0;
        end else begin
            case (fsm_q)
                FSM_IDLE: fsm_d = FSM_SELECT;
                FSM_SELECT: begin
                    if (ok_ev) begin
                        if (seg_q != 4'd0 && !full) begin
                            for (int k = 0; k < MAX_FACT; k++)
                                if (fcnt_q == 3'(k)) facts_d[4*k +: 4] = seg_q;
                            fcnt_d = fcnt_q + 3'd1;
                            seg_d  = '0;
                        end else begin
                            done_d = 1'b1;
                            fsm_d  = FSM_FINISHED;
                        end
                    end else if (next_ev) begin
                        seg_d = (seg_q == 4'd9) ? 4'd1 : seg_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
        if (STATE == ST_READY) begin
            facts_d = '0;
            fcnt_d  = '0;
        end
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fsm_q   <= FSM_IDLE;
            seg_q   <= '0;
            facts_q <= '0;
            fcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            seg_q   <= seg_d;
            facts_q <= facts_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
        end
    end

    assign SEG_Q = seg_q;
    assign FACTS = facts_q;
    assign FCNT  = fcnt_q;
    assign FULL  = full;
    assign DONE  = done_q;
endmodule

// File: tb/tb_prime_key_enc.sv
// tb_prime_key_enc: self-checking bench comparing prime_key_enc against a queue-based entry model
module tb_prime_key_enc;
    import prime_key_enc_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [3:0]  STATE = 4'd0;
    logic        nKEY_NEXT = 1'b1;
    logic        nKEY_OK = 1'b1;
    logic [3:0]  SEG_Q;
    logic [15:0] FACTS;
    logic [2:0]  FCNT;
    logic        FULL;
    logic        DONE;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    bit done_prev = 0;
    bit done_long = 0;

    int m_seg = 0;
    int m_facts[$];
    bit m_fin = 0;
    int m_done = 0;

    prime_key_enc #(.DEB_CYCLES(4), .MAX_FACT(4)) dut (
        .CLK(CLK), .nRST(nRST), .STATE(STATE), .nKEY_NEXT(nKEY_NEXT), .nKEY_OK(nKEY_OK),
        .SEG_Q(SEG_Q), .FACTS(FACTS), .FCNT(FCNT), .FULL(FULL), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (DONE) begin
            done_seen++;
            if (done_prev) done_long = 1;
        end
        done_prev = DONE;
    end

    function automatic logic [15:0] exp_facts();
        logic [15:0] f = '0;
        foreach (m_facts[i]) f[i*4 +: 4] = 4'(m_facts[i]);
        return f;
    endfunction

    task automatic press(input bit nx, input bit ok);
        if (nx) nKEY_NEXT = 1'b0;
        if (ok) nKEY_OK = 1'b0;
        repeat (12) @(negedge CLK);
        nKEY_NEXT = 1'b1;
        nKEY_OK = 1'b1;
        repeat (12) @(negedge CLK);
        if (!m_fin) begin
            if (ok) begin
                if (m_seg != 0 && m_facts.size() < 4) begin
                    m_facts.push_back(m_seg);
                    m_seg = 0;
                end else begin
                    m_done++;
                    m_fin = 1;
                end
            end else if (nx) begin
                m_seg = (m_seg == 9) ? 1 : m_seg + 1;
            end
        end
    endtask

    task automatic set_state(input logic [3:0] s);
        STATE = s;
        if (s != ST_INPUT) begin
            m_seg = 0;
            m_fin = 0;
        end
        if (s == ST_READY) m_facts.delete();
        repeat (3) @(negedge CLK);
    endtask

    task automatic commit(input int v);
        while (m_seg != v) press(1, 0);
        press(0, 1);
    endtask

    task automatic test_reset();
        repeat (5) @(negedge CLK);
        checks++;
        if ({SEG_Q, FACTS, FCNT, FULL, DONE} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {SEG_Q, FACTS, FCNT, FULL, DONE});
        end
        nRST = 1'b1;
        repeat (20) @(negedge CLK);
        checks++;
        if (done_seen !== 0 || SEG_Q !== 4'd0) begin
            errors++;
            $display("FAIL reset_release got seg=%0d done=%0d exp 0/0", SEG_Q, done_seen);
        end
    endtask

    task automatic test_next();
        set_state(ST_INPUT);
        repeat (3) press(1, 0);
        checks++;
        if (SEG_Q !== 4'd3 || FCNT !== 3'd0 || done_seen !== 0) begin
            errors++;
            $display("FAIL next3 got seg=%0d fcnt=%0d done=%0d exp 3/0/0", SEG_Q, FCNT, done_seen);
        end
    endtask

    task automatic test_wrap();
        repeat (6) press(1, 0);
        checks++;
        if (SEG_Q !== 4'd9) begin
            errors++;
            $display("FAIL seg9 got %0d exp 9", SEG_Q);
        end
        press(1, 0);
        checks++;
        if (SEG_Q !== 4'd1) begin
            errors++;
            $display("FAIL wrap got %0d exp 1", SEG_Q);
        end
        press(0, 1);
        checks++;
        if (FACTS[3:0] !== 4'd1 || FCNT !== 3'd1 || SEG_Q !== 4'd0) begin
            errors++;
            $display("FAIL commit1 got f=%0d fcnt=%0d seg=%0d exp 1/1/0", FACTS[3:0], FCNT, SEG_Q);
        end
    endtask

    task automatic test_full();
        set_state(ST_READY);
        set_state(ST_INPUT);
        commit(2);
        commit(3);
        commit(5);
        commit(7);
        checks++;
        if (FCNT !== 3'd4 || FULL !== 1'b1 || FACTS !== 16'h7532) begin
            errors++;
            $display("FAIL full got fcnt=%0d full=%b facts=%h exp 4/1/7532", FCNT, FULL, FACTS);
        end
        press(1, 0);
        press(0, 1);
        checks++;
        if (done_seen !== 1 || FCNT !== 3'd4 || FACTS !== 16'h7532) begin
            errors++;
            $display("FAIL done_full got done=%0d fcnt=%0d facts=%h exp 1/4/7532", done_seen, FCNT, FACTS);
        end
        press(1, 0);
        checks++;
        if (SEG_Q !== 4'(m_seg) || done_seen !== m_done) begin
            errors++;
            $display("FAIL finished_hold got seg=%0d done=%0d exp %0d/%0d", SEG_Q, done_seen, m_seg, m_done);
        end
    endtask

    task automatic test_bounce();
        set_state(ST_READY);
        set_state(ST_INPUT);
        repeat (6) begin
            nKEY_NEXT = 1'b0;
            repeat (3) @(negedge CLK);
            nKEY_NEXT = 1'b1;
            @(negedge CLK);
        end
        nKEY_NEXT = 1'b0;
        repeat (10) @(negedge CLK);
        nKEY_NEXT = 1'b1;
        repeat (12) @(negedge CLK);
        checks++;
        if (SEG_Q !== 4'd1) begin
            errors++;
            $display("FAIL bounce got %0d exp 1", SEG_Q);
        end
        m_seg = 1;
    endtask

    task automatic test_same_cycle();
        press(1, 0);
        press(1, 1);
        checks++;
        if (FACTS[3:0] !== 4'd2 || SEG_Q !== 4'd0 || FCNT !== 3'd1) begin
            errors++;
            $display("FAIL same_cycle got f=%0d seg=%0d fcnt=%0d exp 2/0/1", FACTS[3:0], SEG_Q, FCNT);
        end
    endtask

    task automatic test_random();
        set_state(ST_READY);
        set_state(ST_INPUT);
        for (int i = 0; i < 40; i++) begin
            int r = $urandom_range(0, 11);
            if (r == 0) begin
                set_state(ST_QUESTION);
                set_state(ST_INPUT);
            end else if (r == 1) begin
                set_state(ST_READY);
                set_state(ST_INPUT);
            end else if (r < 5) press(0, 1);
            else if (r == 5) press(1, 1);
            else press(1, 0);
            checks++;
            if (SEG_Q !== 4'(m_seg) || FACTS !== exp_facts() || FCNT !== 3'(m_facts.size())
                || FULL !== (m_facts.size() == 4) || done_seen !== m_done) begin
                errors++;
                $display("FAIL random[%0d] got seg=%0d facts=%h fcnt=%0d full=%b done=%0d exp %0d/%h/%0d/%0d/%0d",
                         i, SEG_Q, FACTS, FCNT, FULL, done_seen, m_seg, exp_facts(), m_facts.size(),
                         m_facts.size() == 4, m_done);
            end
        end
    endtask

    task automatic test_ready_reset();
        set_state(ST_READY);
        set_state(ST_INPUT);
        commit(4);
        commit(6);
        set_state(ST_QUESTION);
        checks++;
        if (FACTS !== 16'h0064 || FCNT !== 3'd2 || SEG_Q !== 4'd0) begin
            errors++;
            $display("FAIL question_keep got facts=%h fcnt=%0d seg=%0d exp 0064/2/0", FACTS, FCNT, SEG_Q);
        end
        set_state(ST_READY);
        checks++;
        if (FACTS !== 16'h0 || FCNT !== 3'd0) begin
            errors++;
            $display("FAIL ready_clear got facts=%h fcnt=%0d exp 0/0", FACTS, FCNT);
        end
        set_state(ST_INPUT);
        commit(8);
        press(1, 0);
        #2 nRST = 1'b0;
        #1;
        checks++;
        if ({SEG_Q, FACTS, FCNT, FULL, DONE} !== 25'd0) begin
            errors++;
            $display("FAIL async_reset got %h exp 0", {SEG_Q, FACTS, FCNT, FULL, DONE});
        end
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        m_facts.delete();
        m_seg = 0;
        m_fin = 0;
    endtask

    initial begin
        test_reset();
        test_next();
        test_wrap();
        test_full();
        test_bounce();
        test_same_cycle();
        test_random();
        test_ready_reset();
        checks++;
        if (done_long !== 1'b0) begin
            errors++;
            $display("FAIL done_width got multi-cycle DONE exp single-cycle");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end
endmodule
